// File: rtl/instr_encoder.sv
// ============================================================================
// instr_encoder: packs instruction field sets into 9-bit words and writes them
// to instruction memory from a start address. Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [9:0]  i_base_addr,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [2:0]  i_in_op,
    input  logic [2:0]  i_in_ra,
    input  logic [2:0]  i_in_rb,
    input  logic [7:0]  i_in_imm,
    input  logic        i_in_last,
    output logic        o_wr_en,
    output logic [9:0]  o_wr_addr,
    output logic [8:0]  o_wr_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [1:0]  o_err_code,
    output logic [10:0] o_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [9:0] c_ADDR_MAX = 10'h3FF;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [9:0]  r_ptr;
    logic        r_fin;
    logic        r_fin_ovf;

    logic        w_start_ok;
    logic        w_xfer;
    logic        w_imm_op;
    logic        w_br;
    logic        w_rng_err;
    logic        w_reg_err;
    logic        w_bad;
    logic        w_good;
    logic        w_at_max;
    logic [8:0]  w_enc;

    assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));
    assign w_xfer     = i_in_valid && o_in_ready;
    assign w_imm_op   = i_in_op[2] && !(&i_in_op);
    assign w_br       = &i_in_op;
    // Immediate fits when all bits above the field's sign bit equal that sign bit.
    assign w_rng_err  = (w_imm_op && !((&i_in_imm[7:3]) || !(|i_in_imm[7:3])))
                     || (w_br     && !((&i_in_imm[7:5]) || !(|i_in_imm[7:5])));
    assign w_reg_err  = w_imm_op && i_in_ra[2];
    assign w_bad      = w_rng_err || w_reg_err;
    assign w_good     = w_xfer && !w_bad;
    assign w_at_max   = (r_ptr == c_ADDR_MAX);

    always_comb begin
        w_enc = {i_in_op, i_in_ra, i_in_rb};
        if (w_imm_op) begin
            w_enc = {i_in_op, i_in_ra[1:0], i_in_imm[3:0]};
        end else if (w_br) begin
            w_enc = {i_in_op, i_in_imm[5:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // r_fin marks the write cycle after a last or overflowing transfer; the
    // FSM stays in LOAD (busy, not ready) for that cycle before leaving.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_LOAD;
            S_LOAD: begin
                if (r_fin) begin
                    w_next = r_fin_ovf ? S_ERR : S_DONE;
                end else if (w_xfer && w_bad) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: w_next = S_IDLE;
            S_ERR:  if (i_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = (r_state == S_LOAD) && !r_fin;
        o_busy     = (r_state == S_LOAD);
        o_done     = (r_state == S_DONE);
        o_err      = (r_state == S_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 10'd0;
            r_fin      <= 1'b0;
            r_fin_ovf  <= 1'b0;
            o_count    <= 11'd0;
            o_err_code <= 2'b00;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= 10'd0;
            o_wr_data  <= 9'd0;
        end else begin
            r_fin     <= w_good && (i_in_last || w_at_max);
            r_fin_ovf <= w_good && !i_in_last && w_at_max;
            o_wr_en   <= w_good;
            if (w_good) begin
                o_wr_addr <= r_ptr;
                o_wr_data <= w_enc;
                o_count   <= o_count + 11'd1;
                if (!w_at_max) begin
                    r_ptr <= r_ptr + 10'd1;
                end
            end
            if (w_start_ok) begin
                r_ptr      <= i_base_addr;
                o_count    <= 11'd0;
                o_err_code <= 2'b00;
            end else if (w_xfer && w_bad) begin
                o_err_code <= w_rng_err ? 2'b01 : 2'b11;
            end else if (r_fin && r_fin_ovf) begin
                o_err_code <= 2'b10;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// tb_instr_encoder: directed and randomized program loads checked against a
// transaction-level model of the encoder. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [2:0]  i_in_op;
    logic [2:0]  i_in_ra;
    logic [2:0]  i_in_rb;
    logic [7:0]  i_in_imm;
    logic        i_in_last;
    logic        o_wr_en;
    logic [9:0]  o_wr_addr;
    logic [8:0]  o_wr_data;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_err_code;
    logic [10:0] o_count;

    int errors = 0;
    int checks = 0;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_ERR  = 2;

    int m_st    = M_IDLE;
    int m_ptr   = 0;
    int m_count = 0;
    int m_code  = 0;

    instr_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_base_addr(i_base_addr),
        .i_in_valid (i_in_valid),
        .o_in_ready (o_in_ready),
        .i_in_op    (i_in_op),
        .i_in_ra    (i_in_ra),
        .i_in_rb    (i_in_rb),
        .i_in_imm   (i_in_imm),
        .i_in_last  (i_in_last),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit imm_bad(input int op, input logic [7:0] imm);
        int s;
        s = int'($signed(imm));
        if (op >= 4 && op <= 6) return (s < -8) || (s > 7);
        if (op == 7) return (s < -32) || (s > 31);
        return 1'b0;
    endfunction

    function automatic int encode(input int op, input int ra, input int rb, input logic [7:0] imm);
        int u;
        u = int'(imm);
        if (op < 4) return op * 64 + ra * 8 + rb;
        if (op < 7) return op * 64 + (ra % 4) * 16 + (u % 16);
        return op * 64 + (u % 64);
    endfunction

    task automatic chk_all_zero(input string tag);
        logic [31:0] v;
        v = {13'd0, o_in_ready, o_wr_en, o_busy, o_done, o_err, o_err_code,
             o_wr_addr != 10'd0, o_wr_data != 9'd0, o_count != 11'd0, 7'd0};
        chk(tag, v, 32'd0);
    endtask

    task automatic do_start(input int base);
        i_start     = 1'b1;
        i_base_addr = 10'(base);
        step();
        i_start = 1'b0;
        if (m_st != M_LOAD) begin
            m_st = M_LOAD; m_ptr = base; m_count = 0; m_code = 0;
        end
        chk("start_ready", 32'(o_in_ready), 32'd1);
        chk("start_count", 32'(o_count), 32'(m_count));
        chk("start_errcode", 32'(o_err_code), 32'd0);
        chk("start_err", 32'(o_err), 32'd0);
    endtask

    task automatic xfer(input int op, input int ra, input int rb, input logic [7:0] imm, input bit last);
        bit rdy, rng, rerr;
        rdy = (m_st == M_LOAD);
        chk("pre_ready", 32'(o_in_ready), 32'(rdy));
        i_in_op = 3'(op); i_in_ra = 3'(ra); i_in_rb = 3'(rb);
        i_in_imm = imm; i_in_last = last; i_in_valid = 1'b1;
        step();
        i_in_valid = 1'b0; i_in_last = 1'b0;
        if (!rdy) begin
            chk("refused_no_wr", 32'(o_wr_en), 32'd0);
            return;
        end
        rng  = imm_bad(op, imm);
        rerr = (op >= 4) && (op <= 6) && (ra > 3);
        if (rng || rerr) begin
            m_st = M_ERR; m_code = rng ? 1 : 3;
            chk("bad_no_wr", 32'(o_wr_en), 32'd0);
            chk("bad_err", 32'(o_err), 32'd1);
            chk("bad_code", 32'(o_err_code), 32'(m_code));
            chk("bad_ready", 32'(o_in_ready), 32'd0);
            return;
        end
        m_count++;
        chk("wr_en", 32'(o_wr_en), 32'd1);
        chk("wr_addr", 32'(o_wr_addr), 32'(m_ptr));
        chk("wr_data", 32'(o_wr_data), 32'(encode(op, ra, rb, imm)));
        chk("count", 32'(o_count), 32'(m_count));
        if (last) begin
            chk("last_ready", 32'(o_in_ready), 32'd0);
            chk("last_busy", 32'(o_busy), 32'd1);
            chk("last_done_early", 32'(o_done), 32'd0);
            step();
            chk("done_pulse", 32'(o_done), 32'd1);
            chk("done_busy", 32'(o_busy), 32'd0);
            chk("done_wr_off", 32'(o_wr_en), 32'd0);
            step();
            chk("done_once", 32'(o_done), 32'd0);
            chk("idle_ready", 32'(o_in_ready), 32'd0);
            chk("count_hold", 32'(o_count), 32'(m_count));
            m_st = M_IDLE;
        end else if (m_ptr == 1023) begin
            chk("ovf_ready", 32'(o_in_ready), 32'd0);
            step();
            m_st = M_ERR; m_code = 2;
            chk("ovf_err", 32'(o_err), 32'd1);
            chk("ovf_code", 32'(o_err_code), 32'd2);
            chk("ovf_wr_off", 32'(o_wr_en), 32'd0);
        end else begin
            m_ptr++;
        end
    endtask

    initial begin
        int len, op, ra, rb, s, base;
        logic [7:0] imm;

        rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_in_valid = 1'b0;
        i_in_op = '0; i_in_ra = '0; i_in_rb = '0; i_in_imm = '0; i_in_last = 1'b0;
        step(); step();
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        step();

        do_start(10'h010);
        xfer(2, 2, 5, 8'h00, 1'b1);

        do_start(10'h100);
        xfer(4, 1, 0, 8'hFD, 1'b0);
        xfer(7, 0, 0, 8'hE0, 1'b1);

        do_start(10'h020);
        xfer(6, 0, 0, 8'h08, 1'b0);
        xfer(0, 1, 1, 8'h00, 1'b0);
        do_start(10'h020);
        xfer(4, 4, 0, 8'h00, 1'b0);
        do_start(10'h030);
        xfer(5, 5, 0, 8'h40, 1'b0);

        do_start(1022);
        xfer(1, 1, 2, 8'h00, 1'b0);
        xfer(3, 3, 4, 8'h00, 1'b0);
        xfer(0, 7, 7, 8'h00, 1'b0);

        // start while loading must not move the pointer
        do_start(10'h200);
        xfer(0, 1, 2, 8'h00, 1'b0);
        do_start(10'h005);
        xfer(7, 0, 0, 8'h1F, 1'b1);

        // start together with in_valid in IDLE: only the start acts
        i_start = 1'b1; i_base_addr = 10'h040; i_in_valid = 1'b1; i_in_op = 3'd1;
        step();
        i_start = 1'b0; i_in_valid = 1'b0;
        m_st = M_LOAD; m_ptr = 10'h040; m_count = 0; m_code = 0;
        chk("startvalid_no_wr", 32'(o_wr_en), 32'd0);
        chk("startvalid_count", 32'(o_count), 32'd0);

        // reset in the cycle after a transfer kills the write port
        i_in_op = 3'd0; i_in_ra = 3'd1; i_in_rb = 3'd1; i_in_valid = 1'b1;
        step();
        i_in_valid = 1'b0;
        chk("pre_reset_wr", 32'(o_wr_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_reset_no_wr", 32'(o_wr_en), 32'd0);
        chk("post_reset_ready", 32'(o_in_ready), 32'd0);
        m_st = M_IDLE;

        // reset before the transfer edge suppresses the pending write
        do_start(10'h080);
        i_in_valid = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        i_in_valid = 1'b0;
        chk("reset_pending_no_wr", 32'(o_wr_en), 32'd0);
        chk("reset_pending_busy", 32'(o_busy), 32'd0);
        m_st = M_IDLE;

        for (int n = 0; n < 40; n++) begin
            base = ($urandom_range(0, 3) == 0) ? 1019 + int'($urandom_range(0, 4))
                                               : int'($urandom_range(0, 1023));
            len = int'($urandom_range(1, 6));
            do_start(base);
            for (int i = 0; i < len && m_st == M_LOAD; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    step();
                    chk("gap_no_wr", 32'(o_wr_en), 32'd0);
                end
                op = int'($urandom_range(0, 7));
                rb = int'($urandom_range(0, 7));
                ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7))
                                                 : int'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) s = int'($urandom_range(0, 255)) - 128;
                else if (op == 7) s = int'($urandom_range(0, 63)) - 32;
                else s = int'($urandom_range(0, 15)) - 8;
                imm = 8'(s);
                xfer(op, ra, rb, imm, i == len - 1);
            end
            if (m_st == M_LOAD) begin
                xfer(2, 0, 0, 8'h00, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  rising-edge clock.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle pulse; begins a program load at base_addr.
REQ-005 base_addr  input  10  first instruction-memory address; sampled with start.
REQ-006 in_valid  input  1  an instruction field set is presented this cycle.
REQ-007 in_ready  output  1  encoder accepts the field set this cycle.
REQ-008 in_op  input  3  opcode: 000 LDR, 001 STR, 010 ADDR, 011 XOR, 100 MOV, 101 LS, 110 ADDI, 111 BR.
REQ-009 in_ra, in_rb  input  3 each  register operands.
REQ-010 in_imm  input  8  two's-complement immediate.
REQ-011 in_last  input  1  marks the final instruction of the program.
REQ-012 wr_en, wr_addr, wr_data  output  1 / 10 / 9  instruction-memory write port.
REQ-013 busy, done  output  1 each  load in progress; one-cycle completion pulse.
REQ-014 err  output  1  sticky error flag; err_code  output  2  cause of the error.
REQ-015 count  output  11  number of instructions written in the current load.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, DONE, ERR.
REQ-017 In IDLE, in_ready SHALL be 0; start SHALL move the FSM to LOAD, set the address pointer to base_addr, and set count to 0.
REQ-018 In LOAD, in_ready SHALL be 1, and start SHALL be ignored.
REQ-019 A transfer SHALL occur only on a cycle with in_valid and in_ready both high.
REQ-020 Encoding for ops 000-011 SHALL be wr_data = {op, ra, rb}.
REQ-021 Encoding for ops 100-110 SHALL be wr_data = {op, ra[1:0], imm[3:0]}.
REQ-022 Encoding for op 111 SHALL be wr_data = {op, imm[5:0]}.
REQ-023 Latency SHALL be 1: wr_en is high for exactly one cycle, in the cycle after the transfer, with wr_addr equal to the pointer value at transfer time; all three write-port outputs SHALL be registered.
REQ-024 After each write, the pointer SHALL increment by 1 and count SHALL increment by 1.
REQ-025 Range errors SHALL be checked at transfer time: imm outside -8..7 for ops 100-110, or imm outside -32..31 for op 111, SHALL set err_code 01.
REQ-026 Register errors SHALL be checked at transfer time: ra > 3 for ops 100-110 SHALL set err_code 11.
REQ-027 A range error and a register error on the same transfer SHALL report err_code 01.
REQ-028 An erroneous transfer SHALL produce no write and SHALL move the FSM to ERR.
REQ-029 Overflow: a valid transfer at pointer 1023 with in_last=0 SHALL still be written, after which the FSM SHALL go to ERR with err_code 10; the pointer SHALL NOT wrap.
REQ-030 A valid transfer with in_last=1 SHALL be written, then the FSM SHALL enter DONE; this takes precedence over overflow at address 1023.
REQ-031 In DONE, done SHALL be 1 for exactly one cycle, followed by IDLE; count SHALL hold its final value until the next start.
REQ-032 In ERR, err SHALL stay 1, err_code SHALL hold, and in_ready SHALL be 0.
REQ-033 start in ERR SHALL clear err and err_code and enter LOAD, exactly as from IDLE.
REQ-034 busy SHALL be 1 in LOAD, and also in the write cycle that follows the last transfer.
REQ-035 start and in_valid asserted together in IDLE: only start SHALL take effect, because in_ready is 0.

Reset
REQ-036 On Reset_n low, the FSM SHALL go to IDLE immediately, asynchronously.
REQ-037 On Reset_n low, all outputs SHALL be 0: in_ready, wr_en, wr_addr, wr_data, busy, done, err, err_code, and count.
REQ-038 Reset asserted during LOAD SHALL suppress any pending write; no wr_en SHALL appear after reset is released.

Verification
REQ-039 start with base_addr=0x010, then ADDR ra=2 rb=5 with in_last=1 -> next cycle wr_en=1, wr_addr=0x010, wr_data=0x095; then done pulses once, count=1.
REQ-040 MOV ra=1 imm=-3, then BR imm=-32 with in_last=1 -> wr_data 0x11D, then 0x1E0, at consecutive addresses; count=2.
REQ-041 ADDI imm=8 -> no wr_en, err=1, err_code=01, in_ready=0; a following start clears err and in_ready returns to 1.
REQ-042 base_addr=1022 with three non-last instructions -> writes at 1022 and 1023, then err_code=10; the third transfer is never accepted.
REQ-043 Reset_n pulsed low in the cycle after a transfer -> no wr_en observed; all outputs 0; FSM in IDLE.
REQ-044 MOV ra=4 imm=0 -> err_code=11, no write.
